wb_commit: RTL and testbench
============================

WB_COMMIT -- requirements
Module: wb_commit

Interface
REQ-001 The block SHALL use one clock, clk, and one asynchronous active-low reset, rst_n; these are its only clock and reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- res_valid  input  1  producer offers a result
- res_rd  input  4  destination register index
- res_data  input  16  result value
- res_ready  output  1  block can accept a result
- wb_stall  input  1  register-file write port unavailable this cycle
- flush  input  1  discard all queued results
- RegWrite  output  1  write strobe to register file
- rw  output  4  register-file write address
- WD  output  16  register-file write data
- fwd_addr  input  4  source register being looked up
- fwd_hit  output  1  a queued result targets fwd_addr
- fwd_data  output  16  youngest queued value for fwd_addr
- busy  output  16  bit i set while any queued entry targets register i
- count  output  3  queued entries, 0..4

Function
REQ-003 The block SHALL hold results in a 4-entry in-order FIFO of {rd[3:0], data[15:0]}, with 2-bit head/tail pointers that wrap 3->0.
REQ-004 A handshake SHALL occur on a rising edge where res_valid=1 and res_ready=1.
REQ-005 res_ready SHALL equal (count<4); it is combinational from registered state only.
REQ-006 A handshake with res_rd=0 SHALL complete and SHALL NOT enqueue anything, because register 0 is never written.
REQ-007 A handshake with res_rd!=0 SHALL enqueue at the tail on that edge.
REQ-008 RegWrite SHALL equal (count!=0 && !wb_stall) and SHALL drive the head's rd on rw and the head's data on WD.
REQ-009 On a rising edge with RegWrite=1, the head SHALL be popped.
REQ-010 When count=0, rw and WD SHALL be 0.
REQ-011 Latency: a result accepted at edge N into an empty FIFO SHALL appear with RegWrite=1 in the cycle after edge N, absent stall.
REQ-012 Simultaneous push and pop in the same edge SHALL leave count unchanged and SHALL preserve order.
REQ-013 When full, pop SHALL proceed; res_ready remains 0 for that cycle.
REQ-014 wb_stall=1 SHALL freeze the head and hold RegWrite=0 while pushes continue until full.
REQ-015 flush=1 on an edge SHALL set count=0 and reset both pointers to 0. Flush has priority over push and pop on that edge: no write is committed and no result is accepted, even if the handshake signals are high.
REQ-016 RegWrite SHALL still reflect the pre-flush state during the cycle in which flush is asserted.
REQ-017 busy[i] SHALL be 1 exactly when some valid entry has rd=i; busy[0] is always 0.
REQ-018 busy SHALL be derived combinationally from the FIFO contents.
REQ-019 fwd_hit SHALL be 1 when fwd_addr!=0 and some valid entry matches fwd_addr.
REQ-020 fwd_data SHALL be the data of the youngest matching entry (closest to tail), or 0 when there is no hit.
REQ-021 Entries leaving the FIFO SHALL stop contributing to busy and fwd in the cycle after their pop edge.

Reset
REQ-022 While rst_n=0 the block SHALL hold count=0, pointers=0, RegWrite=0, rw=0, WD=0, busy=0, fwd_hit=0, fwd_data=0 and res_ready=1, independent of clk.
REQ-023 Storage contents are don't-care after reset; no output SHALL depend on them.
REQ-024 Reset asserted mid-operation SHALL drop all queued entries with no further RegWrite pulse.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Push {rd=5, 0xDADA}, then idle -> next cycle RegWrite=1, rw=5, WD=0xDADA; count 1->0; busy[5] set then clears.
- wb_stall=1, push rd=3,4,3,7 -> count=4, res_ready=0, busy=0x0098. fwd_addr=3 gives fwd_data = the third value. Release stall -> four writes in order 3,4,3,7 on consecutive cycles.
- Full FIFO with stall=0 and res_valid held -> pop on the first edge, accept on the next; order preserved and no loss.
- Push rd=0, 0xFFFF -> handshake completes, count stays 0, RegWrite never asserts.
- Three entries queued, flush with res_valid=1 -> count=0 next cycle, new result not accepted, busy=0.
- rst_n low asynchronously with count=2 -> outputs go to reset values immediately; after release, RegWrite=0 and res_ready=1.

Source files
------------

// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - 4-entry in-order writeback commit queue with busy scoreboard and forwarding
module wb_commit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [3:0]  res_rd,
  input  logic [15:0] res_data,
  output logic        res_ready,
  input  logic        wb_stall,
  input  logic        flush,
  output logic        RegWrite,
  output logic [3:0]  rw,
  output logic [15:0] WD,
  input  logic [3:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [15:0] fwd_data,
  output logic [15:0] busy,
  output logic [2:0]  count
);

  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [2:0]  count_q, count_d;
  logic [3:0]  rd_q   [4];
  logic [3:0]  rd_d   [4];
  logic [15:0] data_q [4];
  logic [15:0] data_d [4];
  logic        push;
  logic        pop;
  logic [1:0]  slot;

  always_comb begin
    res_ready = (count_q < 3'd4);
    RegWrite  = (count_q != 3'd0) && !wb_stall;
    rw        = (count_q != 3'd0) ? rd_q[head_q]   : 4'd0;
    WD        = (count_q != 3'd0) ? data_q[head_q] : 16'd0;
    count     = count_q;
    // Flush wins over both ends of the queue on the same edge.
    push      = res_valid && res_ready && (res_rd != 4'd0) && !flush;
    pop       = RegWrite && !flush;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (flush) begin
      head_d  = 2'd0;
      tail_d  = 2'd0;
      count_d = 3'd0;
    end else begin
      if (push) begin
        rd_d[tail_q]   = res_rd;
        data_d[tail_q] = res_data;
        tail_d         = tail_q + 2'd1;
      end
      if (pop) begin
        head_d = head_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    busy     = 16'd0;
    fwd_hit  = 1'b0;
    fwd_data = 16'd0;
    slot     = head_q;
    for (int k = 0; k < 4; k++) begin
      slot = head_q + 2'(k);
      if (3'(k) < count_q) begin
        busy[rd_q[slot]] = 1'b1;
        if ((fwd_addr != 4'd0) && (rd_q[slot] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[slot];
        end
      end
    end
    busy[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        rd_q[i]   <= 4'd0;
        data_q[i] <= 16'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// tb/tb_wb_commit.sv - scoreboard bench for wb_commit
module tb_wb_commit;

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic [3:0]  res_rd;
  logic [15:0] res_data;
  logic        res_ready;
  logic        wb_stall;
  logic        flush;
  logic        RegWrite;
  logic [3:0]  rw;
  logic [15:0] WD;
  logic [3:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
  logic [15:0] busy;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  logic [19:0] exp_q [$];
  logic [19:0] head_e;
  logic [15:0] m_busy;
  logic        m_hit;
  logic [15:0] m_fdata;
  logic        m_wr;
  int          m_n;

  wb_commit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .res_valid(res_valid),
    .res_rd   (res_rd),
    .res_data (res_data),
    .res_ready(res_ready),
    .wb_stall (wb_stall),
    .flush    (flush),
    .RegWrite (RegWrite),
    .rw       (rw),
    .WD       (WD),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .busy     (busy),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: checks every cycle against the queue, then applies the upcoming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      m_n     = exp_q.size();
      m_busy  = 16'd0;
      m_hit   = 1'b0;
      m_fdata = 16'd0;
      for (int k = 0; k < m_n; k++) begin
        m_busy[exp_q[k][19:16]] = 1'b1;
        if (fwd_addr != 4'd0 && exp_q[k][19:16] == fwd_addr) begin
          m_hit   = 1'b1;
          m_fdata = exp_q[k][15:0];
        end
      end
      m_busy[0] = 1'b0;
      m_wr = (m_n != 0) && !wb_stall;
      vectors++;
      if (count !== 3'(m_n) || res_ready !== (m_n < 4) || RegWrite !== m_wr) begin
        miscompares++;
        $display("FAIL sb_state: count=%0d ready=%b wr=%b, expected count=%0d ready=%b wr=%b",
                 count, res_ready, RegWrite, m_n, (m_n < 4), m_wr);
      end
      vectors++;
      if (busy !== m_busy || fwd_hit !== m_hit || fwd_data !== m_fdata) begin
        miscompares++;
        $display("FAIL sb_fwd: busy=%h hit=%b fdata=%h, expected busy=%h hit=%b fdata=%h",
                 busy, fwd_hit, fwd_data, m_busy, m_hit, m_fdata);
      end
      head_e = (m_n != 0) ? exp_q[0] : 20'd0;
      vectors++;
      if (rw !== head_e[19:16] || WD !== head_e[15:0]) begin
        miscompares++;
        $display("FAIL sb_head: rw=%0d WD=%h, expected rw=%0d WD=%h", rw, WD, head_e[19:16], head_e[15:0]);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_wr) void'(exp_q.pop_front());
        if (res_valid && m_n < 4 && res_rd != 4'd0) exp_q.push_back({res_rd, res_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0;
    res_rd    = 4'd0;
    res_data  = 16'd0;
    wb_stall  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if (count !== 3'd0 || RegWrite !== 1'b0 || rw !== 4'd0 || WD !== 16'd0 ||
        busy !== 16'd0 || fwd_hit !== 1'b0 || fwd_data !== 16'd0 || res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset: count=%0d wr=%b rw=%0d WD=%h busy=%h hit=%b ready=%b, expected 0/0/0/0/0/0/1",
               count, RegWrite, rw, WD, busy, fwd_hit, res_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    fwd_addr  = 4'd5;
    res_valid = 1'b1;
    res_rd    = 4'd5;
    res_data  = 16'hDADA;
    tick();
    res_valid = 1'b0;
    vectors++;
    if (count !== 3'd1 || RegWrite !== 1'b1 || rw !== 4'd5 || WD !== 16'hDADA || busy !== 16'h0020) begin
      miscompares++;
      $display("FAIL single_push: count=%0d wr=%b rw=%0d WD=%h busy=%h, expected 1/1/5/dada/0020",
               count, RegWrite, rw, WD, busy);
    end
    tick();
    vectors++;
    if (count !== 3'd0 || RegWrite !== 1'b0 || busy !== 16'd0) begin
      miscompares++;
      $display("FAIL single_drain: count=%0d wr=%b busy=%h, expected 0/0/0000", count, RegWrite, busy);
    end
  endtask

  task automatic test_stall();
    logic [3:0]  rds  [4];
    logic [15:0] vals [4];
    rds  = '{4'd3, 4'd4, 4'd3, 4'd7};
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1;
      res_rd    = rds[i];
      res_data  = vals[i];
      tick();
    end
    res_valid = 1'b0;
    fwd_addr  = 4'd3;
    #1;
    vectors++;
    if (count !== 3'd4 || res_ready !== 1'b0 || busy !== 16'h0098 || fwd_hit !== 1'b1 || fwd_data !== 16'h3333) begin
      miscompares++;
      $display("FAIL stall_full: count=%0d ready=%b busy=%h hit=%b fdata=%h, expected 4/0/0098/1/3333",
               count, res_ready, busy, fwd_hit, fwd_data);
    end
    wb_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (RegWrite !== 1'b1 || rw !== rds[i] || WD !== vals[i]) begin
        miscompares++;
        $display("FAIL stall_drain%0d: wr=%b rw=%0d WD=%h, expected 1/%0d/%h", i, RegWrite, rw, WD, rds[i], vals[i]);
      end
      tick();
    end
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL stall_empty: count=%0d, expected 0", count);
    end
  endtask

  task automatic test_full_pop();
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_valid = 1'b1;
      res_rd    = 4'(i + 8);
      res_data  = 16'hA000 + 16'(i);
      tick();
    end
    wb_stall = 1'b0;
    res_rd   = 4'd12;
    res_data = 16'hBEEF;
    #1;
    vectors++;
    if (res_ready !== 1'b0 || RegWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop_ready: ready=%b wr=%b, expected 0/1", res_ready, RegWrite);
    end
    tick();
    vectors++;
    if (count !== 3'd3 || res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pop_first: count=%0d ready=%b, expected 3/1", count, res_ready);
    end
    tick();
    res_valid = 1'b0;
    vectors++;
    if (count !== 3'd3 || rw !== 4'd10) begin
      miscompares++;
      $display("FAIL full_pop_second: count=%0d rw=%0d, expected 3/10", count, rw);
    end
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (count !== 3'd0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL full_pop_drain: count=%0d pending=%0d, expected 0/0", count, exp_q.size());
    end
  endtask

  task automatic test_rd0();
    res_valid = 1'b1;
    res_rd    = 4'd0;
    res_data  = 16'hFFFF;
    #1;
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd0_ready: ready=%b, expected 1", res_ready);
    end
    tick();
    res_valid = 1'b0;
    vectors++;
    if (count !== 3'd0 || RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL rd0_drop: count=%0d wr=%b, expected 0/0", count, RegWrite);
    end
    tick();
  endtask

  task automatic test_flush();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1;
      res_rd    = 4'(i + 1);
      res_data  = 16'hC000 + 16'(i);
      tick();
    end
    wb_stall = 1'b0;
    res_rd   = 4'd9;
    res_data = 16'h5A5A;
    flush    = 1'b1;
    #1;
    vectors++;
    if (RegWrite !== 1'b1 || count !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_pre: wr=%b count=%0d, expected 1/3", RegWrite, count);
    end
    tick();
    flush     = 1'b0;
    res_valid = 1'b0;
    vectors++;
    if (count !== 3'd0 || busy !== 16'd0 || RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_post: count=%0d busy=%h wr=%b, expected 0/0000/0", count, busy, RegWrite);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    wb_stall = 1'b1;
    fwd_addr = 4'd6;
    for (int i = 0; i < 2; i++) begin
      res_valid = 1'b1;
      res_rd    = 4'(i + 6);
      res_data  = 16'hD000 + 16'(i);
      tick();
    end
    res_valid = 1'b0;
    wb_stall  = 1'b0;
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("FAIL rst_mid_pre: count=%0d, expected 2", count);
    end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    vectors++;
    if (count !== 3'd0 || RegWrite !== 1'b0 || rw !== 4'd0 || WD !== 16'd0 ||
        busy !== 16'd0 || fwd_hit !== 1'b0 || fwd_data !== 16'd0 || res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_async: count=%0d wr=%b rw=%0d busy=%h hit=%b ready=%b, expected 0/0/0/0000/0/1",
               count, RegWrite, rw, busy, fwd_hit, res_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (RegWrite !== 1'b0 || res_ready !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid_release: wr=%b ready=%b count=%0d, expected 0/1/0", RegWrite, res_ready, count);
    end
    tick();
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    fwd_addr    = 4'd0;
    idle_inputs();
    test_reset();
    test_single();
    test_stall();
    test_full_pop();
    test_rd0();
    test_flush();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_pending: pending=%0d, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
